// File: rtl/heater_mode_seq.sv
`default_nettype none
// ============================================================================
// Module  : heater_mode_seq
// Purpose : Bath-heater mode sequencer with boot blink, per-mode cool-down,
//           light toggle and a single-clock animation tick prescaler.
// Revision: 1.0  initial release
// ============================================================================
module heater_mode_seq #(
    parameter int                     TICK_DIV      = 25_000_000,
    parameter int                     NUM_MODES     = 4,
    parameter int                     NUM_FRAMES    = 4,
    parameter int                     BOOT_TICKS    = 4,
    parameter int                     TICKS_PER_SEC = 2,
    parameter logic [8*NUM_MODES-1:0] COOL_TICKS    = {8'd0, 8'd8, 8'd4, 8'd0},
    localparam int                    MW            = $clog2(NUM_MODES + 1),
    localparam int                    FW            = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic [NUM_MODES:0]   key,
    output logic [MW-1:0]        mode,
    output logic [FW-1:0]        frame,
    output logic                 booting,
    output logic                 blink,
    output logic                 cooling,
    output logic [7:0]           remain_sec,
    output logic                 light,
    output logic                 tick
);

    localparam int                c_DW           = $clog2(TICK_DIV);
    localparam int                c_BW           = (BOOT_TICKS > 0) ? $clog2(BOOT_TICKS + 1) : 1;
    localparam logic              c_BOOT_EN      = (BOOT_TICKS > 0);
    localparam logic [MW-1:0]     c_STANDBY_MODE = MW'(NUM_MODES);
    localparam logic [FW-1:0]     c_LAST_FRAME   = FW'(NUM_FRAMES - 1);
    localparam logic [c_BW-1:0]   c_BOOT_LOAD    = c_BW'(BOOT_TICKS);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_STANDBY = 2'd1,
        S_RUN     = 2'd2,
        S_COOL    = 2'd3
    } state_t;

    localparam state_t c_RST_STATE = c_BOOT_EN ? S_BOOT : S_STANDBY;

    // Registered state
    state_t            r_state;
    logic [MW-1:0]     r_mode;
    logic [FW-1:0]     r_frame;
    logic [c_BW-1:0]   r_boot_cnt;
    logic              r_booting;
    logic              r_blink;
    logic              r_cooling;
    logic [7:0]        r_cool_cnt;
    logic [7:0]        r_remain;
    logic              r_light;
    logic              r_tick;
    logic [c_DW-1:0]   r_div_cnt;
    logic [NUM_MODES:0] r_key_q;

    // Combinational
    logic                 w_tick;
    logic [NUM_MODES:0]   w_press;
    logic [NUM_MODES-1:0] w_mode_press;
    logic                 w_light_press;
    logic                 w_hit;
    logic                 w_multi;
    logic                 w_single;
    logic [MW-1:0]        w_press_idx;
    logic [7:0]           w_cool_len;
    logic [FW-1:0]        w_frame_adv;
    state_t               w_nxt_state;
    logic [MW-1:0]        w_nxt_mode;
    logic [FW-1:0]        w_nxt_frame;
    logic [c_BW-1:0]      w_nxt_boot_cnt;
    logic                 w_nxt_blink;
    logic [7:0]           w_nxt_cool_cnt;
    logic                 w_nxt_light;
    logic [8:0]           w_sec_sum;
    logic [8:0]           w_secs;
    logic [7:0]           w_nxt_remain;

    // Prescaler: tick state changes land on the same edge the tick pulse rises
    assign w_tick = (r_div_cnt == c_DW'(TICK_DIV - 1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tick    <= w_tick;
            r_div_cnt <= w_tick ? '0 : r_div_cnt + c_DW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_q <= '0;
        end else begin
            r_key_q <= key;
        end
    end

    assign w_press       = key & ~r_key_q;
    assign w_mode_press  = w_press[NUM_MODES-1:0];
    assign w_light_press = w_press[NUM_MODES];

    // Encode the mode press; more than one at once is treated as no press
    always_comb begin
        w_hit       = 1'b0;
        w_multi     = 1'b0;
        w_press_idx = '0;
        w_cool_len  = 8'd0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (w_mode_press[i]) begin
                if (w_hit) begin
                    w_multi = 1'b1;
                end
                w_hit       = 1'b1;
                w_press_idx = MW'(i);
                w_cool_len  = COOL_TICKS[8*i +: 8];
            end
        end
    end

    assign w_single    = w_hit & ~w_multi;
    assign w_frame_adv = (r_frame == c_LAST_FRAME) ? '0 : r_frame + FW'(1);

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_mode     = r_mode;
        w_nxt_frame    = r_frame;
        w_nxt_boot_cnt = r_boot_cnt;
        w_nxt_blink    = r_blink;
        w_nxt_cool_cnt = r_cool_cnt;
        w_nxt_light    = r_light;

        case (r_state)
            S_BOOT: begin
                if (w_tick) begin
                    w_nxt_blink    = ~r_blink;
                    w_nxt_boot_cnt = r_boot_cnt - c_BW'(1);
                    if (r_boot_cnt <= c_BW'(1)) begin
                        w_nxt_state = S_STANDBY;
                        w_nxt_blink = 1'b0;
                    end
                end
            end
            S_STANDBY: begin
                if (w_single) begin
                    w_nxt_state = S_RUN;
                    w_nxt_mode  = w_press_idx;
                    w_nxt_frame = '0;
                end
            end
            S_RUN: begin
                if (w_single) begin
                    if (w_press_idx != r_mode) begin
                        w_nxt_mode  = w_press_idx;
                        w_nxt_frame = '0;
                    end else if (w_cool_len == 8'd0) begin
                        w_nxt_state = S_STANDBY;
                        w_nxt_mode  = c_STANDBY_MODE;
                        w_nxt_frame = '0;
                    end else begin
                        w_nxt_state    = S_COOL;
                        w_nxt_cool_cnt = w_cool_len;
                    end
                end else if (w_tick) begin
                    w_nxt_frame = w_frame_adv;
                end
            end
            S_COOL: begin
                if (w_single) begin
                    // Re-pressing the cooling mode resumes it without restarting the animation
                    w_nxt_state    = S_RUN;
                    w_nxt_cool_cnt = 8'd0;
                    if (w_press_idx != r_mode) begin
                        w_nxt_mode  = w_press_idx;
                        w_nxt_frame = '0;
                    end
                end else if (w_tick) begin
                    if (r_cool_cnt <= 8'd1) begin
                        w_nxt_state    = S_STANDBY;
                        w_nxt_mode     = c_STANDBY_MODE;
                        w_nxt_frame    = '0;
                        w_nxt_cool_cnt = 8'd0;
                    end else begin
                        w_nxt_cool_cnt = r_cool_cnt - 8'd1;
                        w_nxt_frame    = w_frame_adv;
                    end
                end
            end
            default: begin
                w_nxt_state = S_STANDBY;
                w_nxt_mode  = c_STANDBY_MODE;
                w_nxt_frame = '0;
            end
        endcase

        if (w_light_press && (r_state != S_BOOT)) begin
            w_nxt_light = ~r_light;
        end
    end

    // Remaining seconds, rounded up, as two BCD digits
    always_comb begin
        w_sec_sum    = {1'b0, w_nxt_cool_cnt} + 9'(TICKS_PER_SEC - 1);
        w_secs       = w_sec_sum / 9'(TICKS_PER_SEC);
        w_nxt_remain = 8'h00;
        if (w_nxt_state == S_COOL) begin
            w_nxt_remain = {4'(w_secs / 9'd10), 4'(w_secs % 9'd10)};
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_RST_STATE;
            r_mode     <= c_STANDBY_MODE;
            r_frame    <= '0;
            r_boot_cnt <= c_BOOT_LOAD;
            r_booting  <= c_BOOT_EN;
            r_blink    <= c_BOOT_EN;
            r_cooling  <= 1'b0;
            r_cool_cnt <= 8'd0;
            r_remain   <= 8'h00;
            r_light    <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_mode     <= w_nxt_mode;
            r_frame    <= w_nxt_frame;
            r_boot_cnt <= w_nxt_boot_cnt;
            r_booting  <= (w_nxt_state == S_BOOT);
            r_blink    <= w_nxt_blink;
            r_cooling  <= (w_nxt_state == S_COOL);
            r_cool_cnt <= w_nxt_cool_cnt;
            r_remain   <= w_nxt_remain;
            r_light    <= w_nxt_light;
        end
    end

    assign mode       = r_mode;
    assign frame      = r_frame;
    assign booting    = r_booting;
    assign blink      = r_blink;
    assign cooling    = r_cooling;
    assign remain_sec = r_remain;
    assign light      = r_light;
    assign tick       = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_heater_mode_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_heater_mode_seq
// Purpose : Directed self-checking bench for heater_mode_seq (TICK_DIV = 4).
// Revision: 1.0  initial release
// ============================================================================
module tb_heater_mode_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] key;
    logic [2:0] mode;
    logic [1:0] frame;
    logic       booting;
    logic       blink;
    logic       cooling;
    logic [7:0] remain_sec;
    logic       light;
    logic       tick;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    heater_mode_seq #(
        .TICK_DIV (4)
    ) dut (
        .sys_clk    (clk),
        .rst_n      (rst_n),
        .key        (key),
        .mode       (mode),
        .frame      (frame),
        .booting    (booting),
        .blink      (blink),
        .cooling    (cooling),
        .remain_sec (remain_sec),
        .light      (light),
        .tick       (tick)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] exp_rem [7] = '{8'h04, 8'h03, 8'h03, 8'h02, 8'h02, 8'h01, 8'h01};

    initial begin
        rst_n = 1'b0;
        key   = '0;
        cyc(2);
        check_val("rst_mode",    mode,       4);
        check_val("rst_frame",   frame,      0);
        check_val("rst_booting", booting,    1);
        check_val("rst_blink",   blink,      1);
        check_val("rst_cooling", cooling,    0);
        check_val("rst_remain",  remain_sec, 0);
        check_val("rst_light",   light,      0);
        check_val("rst_tick",    tick,       0);

        // Boot blink; a light press during boot must be ignored
        rst_n = 1'b1;
        cyc(1);                                   // edge 1
        check_val("boot_e1_booting", booting, 1);
        check_val("boot_e1_blink",   blink,   1);
        key = 5'b10000;
        cyc(1);                                   // edge 2
        key = '0;
        cyc(1);                                   // edge 3
        check_val("boot_e3_blink", blink, 1);
        check_val("boot_e3_tick",  tick,  0);
        cyc(1);                                   // edge 4: first tick
        check_val("boot_e4_tick",  tick,  1);
        check_val("boot_e4_blink", blink, 0);
        check_val("boot_light_locked", light, 0);
        cyc(1);                                   // edge 5
        check_val("boot_e5_tick", tick, 0);
        cyc(3);                                   // edge 8
        check_val("boot_e8_blink", blink, 1);
        cyc(7);                                   // edge 15
        check_val("boot_e15_booting", booting, 1);
        cyc(1);                                   // edge 16
        check_val("boot_done_booting", booting, 0);
        check_val("boot_done_blink",   blink,   0);
        check_val("boot_done_mode",    mode,    4);
        check_val("boot_done_frame",   frame,   0);

        // RUN(0) animation and immediate shutdown
        key = 5'b00001;
        cyc(1);                                   // edge 17
        key = '0;
        check_val("run0_mode",  mode,  0);
        check_val("run0_frame", frame, 0);
        cyc(3);                                   // edge 20
        check_val("run0_frame_t1", frame, 1);
        cyc(4);
        check_val("run0_frame_t2", frame, 2);
        cyc(4);
        check_val("run0_frame_t3", frame, 3);
        cyc(4);                                   // edge 32
        check_val("run0_frame_wrap", frame, 0);
        key = 5'b00001;
        cyc(1);                                   // edge 33
        check_val("off0_mode",    mode,    4);
        check_val("off0_cooling", cooling, 0);

        // Cool-down of mode 2; press coincides with a tick edge
        key = 5'b00100;
        cyc(1);                                   // edge 34
        key = '0;
        check_val("run2_mode", mode, 2);
        cyc(1);                                   // edge 35
        key = 5'b00100;
        cyc(1);                                   // edge 36 (tick)
        key = '0;
        check_val("cool2_cooling", cooling,    1);
        check_val("cool2_remain",  remain_sec, 8'h04);
        check_val("cool2_mode",    mode,       2);
        check_val("cool2_frame_no_adv", frame, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(4);
            check_val($sformatf("cool2_remain_t%0d", i + 1), remain_sec, exp_rem[i]);
            check_val($sformatf("cool2_frame_t%0d", i + 1), frame, (i + 1) % 4);
            check_val($sformatf("cool2_cooling_t%0d", i + 1), cooling, 1);
        end
        cyc(4);                                   // edge 68: 8th tick
        check_val("cool2_end_cooling", cooling,    0);
        check_val("cool2_end_mode",    mode,       4);
        check_val("cool2_end_remain",  remain_sec, 0);

        // Cancel and switch during COOL(1)
        key = 5'b00010;
        cyc(1);                                   // edge 69
        key = '0;
        check_val("run1_mode", mode, 1);
        cyc(1);                                   // edge 70
        key = 5'b00010;
        cyc(1);                                   // edge 71
        key = '0;
        check_val("cool1_cooling", cooling,    1);
        check_val("cool1_remain",  remain_sec, 8'h02);
        cyc(1);                                   // edge 72 (tick)
        check_val("cool1_remain_t1", remain_sec, 8'h02);
        check_val("cool1_frame_t1",  frame,      1);
        key = 5'b00010;
        cyc(1);                                   // edge 73
        key = '0;
        check_val("cancel_mode",    mode,       1);
        check_val("cancel_cooling", cooling,    0);
        check_val("cancel_remain",  remain_sec, 0);
        check_val("cancel_frame",   frame,      1);
        cyc(1);                                   // edge 74
        key = 5'b00010;
        cyc(1);                                   // edge 75
        check_val("cool1b_cooling", cooling, 1);
        key = 5'b01000;
        cyc(1);                                   // edge 76 (tick)
        key = '0;
        check_val("switch_mode",    mode,       3);
        check_val("switch_frame",   frame,      0);
        check_val("switch_remain",  remain_sec, 0);
        check_val("switch_cooling", cooling,    0);

        // Simultaneous mode presses discarded, light still toggles
        key = 5'b00001;
        cyc(1);                                   // edge 77
        key = '0;
        check_val("run0b_mode", mode, 0);
        cyc(1);                                   // edge 78
        key = 5'b10110;
        cyc(1);                                   // edge 79
        key = '0;
        check_val("simul_mode",  mode,  0);
        check_val("simul_light", light, 1);
        cyc(1);                                   // edge 80 (tick)
        check_val("simul_frame", frame, 1);

        // Mid-operation reset during COOL(2)
        key = 5'b00100;
        cyc(1);                                   // edge 81
        key = '0;
        cyc(1);                                   // edge 82
        key = 5'b00100;
        cyc(1);                                   // edge 83
        key = '0;
        check_val("cool2b_cooling", cooling,    1);
        check_val("cool2b_remain",  remain_sec, 8'h04);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_mode",    mode,       4);
        check_val("midrst_cooling", cooling,    0);
        check_val("midrst_remain",  remain_sec, 0);
        check_val("midrst_booting", booting,    1);
        check_val("midrst_blink",   blink,      1);
        check_val("midrst_light",   light,      0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        check_val("reboot_booting", booting, 1);
        check_val("reboot_mode",    mode,    4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
